// File: rtl/bin2bcd_if.sv
// bin2bcd_if: handshake/data bundle between a binary source and bin2bcd_seq.
//   in_valid  : source -> converter, bin is valid this cycle
//   in_ready  : converter -> source, converter idle; accept on in_valid&&in_ready
//   bin       : source -> converter, WIDTH-bit binary value
//   out_valid : converter -> sink, one-cycle strobe for a new bcd result
//   bcd       : converter -> sink, packed BCD, digit 0 (units) in bcd[3:0]
//   blank     : converter -> sink, leading-zero blanking (only with BIN2BCD_BLANK_EN)
// Modports: master = source/sink side, slave = converter side.
interface bin2bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output in_valid, bin, input in_ready, out_valid, bcd, blank);
  modport slave  (input in_valid, bin, output in_ready, out_valid, bcd, blank);
`else
  modport master (output in_valid, bin, input in_ready, out_valid, bcd);
  modport slave  (input in_valid, bin, output in_ready, out_valid, bcd);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit
// per clock). Accepts a WIDTH-bit value when idle, shifts it through a BCD
// work register for WIDTH cycles, then presents the result on bcd together
// with a one-cycle out_valid strobe.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous reset, active-low
//   bus    : bin2bcd_if.slave (in_valid/in_ready/bin in, out_valid/bcd out,
//            plus blank when BIN2BCD_BLANK_EN is defined)
// Configuration macro: BIN2BCD_BLANK_EN adds the registered blank[DIGITS-1:0]
// output (leading-zero blanking, blank[0] always 0).
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Every WIDTH-bit value must fit in DIGITS decimal digits.
  generate
    if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            out_valid_q, out_valid_d;

  // Any nibble of 5 or more gets +3; a nibble is at most 9 here, so the
  // sum stays within 4 bits and never carries into the next digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] w);
    logic [BW-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // blank[i] is set while digit i and everything above it are zero;
  // the units digit is never blanked so zero still shows as "0".
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v);
    logic [DIGITS-1:0] b;
    logic              hz;
    b  = '0;
    hz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz   = hz && (v[4*i +: 4] == 4'd0);
      b[i] = hz;
    end
    return b;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_valid_d = 1'b0;
`ifdef BIN2BCD_BLANK_EN
    blank_d     = blank_q;
`endif
    case (state_q)
      IDLE: begin
        // in_ready is implied by being in IDLE.
        if (bus.in_valid) begin
          state_d = SHIFT;
          shift_d = bus.bin;
          work_d  = '0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        // Correct first, then shift: shift MSB enters the work LSB.
        {work_d, shift_d} = {add3(work_q), shift_q} << 1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          bcd_d       = work_d;
          out_valid_d = 1'b1;
`ifdef BIN2BCD_BLANK_EN
          blank_d     = blank_of(work_d);
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
`ifdef BIN2BCD_BLANK_EN
  assign bus.blank     = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: bench for bin2bcd_seq (WIDTH=8, DIGITS=3). A negedge
// monitor records every accepted value and compares each out_valid result
// with a decimal reference model; directed and random stimulus drive it.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, packed four bits per digit.
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r = r | (32'(x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: digit i (i>=1) is blanked when the value is below 10**i.
  function automatic logic [31:0] blank_ref(input int v);
    logic [31:0] b;
    int          p;
    b = '0;
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  // Monitor / scoreboard state
  int          cyc      = 0;
  int          acc_v[$];
  int          acc_c[$];
  int          last_acc = -1000;
  int          prev_acc = -1;
  bit          b2b      = 1'b0;
  logic [31:0] hold_exp = '0;
  int          ov_count = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int v;
    int c;
    if (!rst_n) begin
      acc_v.delete();
      acc_c.delete();
      hold_exp = '0;
      last_acc = -1000;
      prev_acc = -1;
    end else begin
      // Cycle numbering: the accept edge ends cycle T, so a negedge with
      // cyc == last_acc + k observes cycle T+k.
      if (cyc > last_acc && cyc <= last_acc + WIDTH + 1)
        check("in_ready_busy", bus.in_ready, 0);
      else if (cyc == last_acc + WIDTH + 2)
        check("in_ready_idle", bus.in_ready, 1);

      if (bus.out_valid) begin
        ov_count++;
        if (acc_v.size() == 0) begin
          check("out_valid_unexpected", bus.out_valid, 0);
        end else begin
          v = acc_v.pop_front();
          c = acc_c.pop_front();
          check("bcd", bus.bcd, to_bcd(v));
          check("latency", cyc - c, WIDTH + 1);
`ifdef BIN2BCD_BLANK_EN
          check("blank", bus.blank, blank_ref(v));
`endif
          hold_exp = to_bcd(v);
        end
      end else begin
        check("bcd_hold", bus.bcd, hold_exp);
      end

      if (bus.in_valid && bus.in_ready) begin
        acc_v.push_back(int'(bus.bin));
        acc_c.push_back(cyc);
        if (b2b && prev_acc >= 0) check("accept_spacing", cyc - prev_acc, WIDTH + 2);
        prev_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  task automatic send(input int v);
    int n;
    n = 0;
    bus.bin      = v[WIDTH-1:0];
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 40);
    if (!bus.in_ready) check("send_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((acc_v.size() != 0 || !bus.in_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("done_timeout", acc_v.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int          bnd_v[5] = '{0, 9, 10, 99, 100};
  logic [11:0] bnd_e[5] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
`ifdef BIN2BCD_BLANK_EN
  int          blk_v[4] = '{5, 40, 0, 100};
  logic [2:0]  blk_e[4] = '{3'b110, 3'b100, 3'b110, 3'b000};
`endif

  initial begin
    int ov_before;
    bus.in_valid = 1'b0;
    bus.bin      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_bcd", bus.bcd, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-scale conversion
    send(255);
    wait_done();
    check("bcd_255", bus.bcd, 12'h255);

    // Decimal boundaries
    for (int i = 0; i < 5; i++) begin
      send(bnd_v[i]);
      wait_done();
      check("boundary", bus.bcd, bnd_e[i]);
    end

`ifdef BIN2BCD_BLANK_EN
    for (int i = 0; i < 4; i++) begin
      send(blk_v[i]);
      wait_done();
      check("blank_directed", bus.blank, blk_e[i]);
    end
`endif

    // Random values
    for (int i = 0; i < 30; i++) begin
      send(int'($urandom_range(0, 255)));
      wait_done();
    end

    // Busy: requests during SHIFT are ignored, bin is sampled only on accept
    send(42);
    bus.in_valid = 1'b1;
    bus.bin      = 8'd7;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done();
    check("busy_result", bus.bcd, 12'h042);
    repeat (5) @(posedge clk);
    #1;
    check("busy_hold", bus.bcd, 12'h042);

    // Reset in the middle of a conversion
    send(200);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", bus.bcd, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov_before = ov_count;
    repeat (12) @(posedge clk);
    #1;
    check("no_stale_out_valid", ov_count - ov_before, 0);
    check("post_reset_in_ready", bus.in_ready, 1);

    // Back-to-back from a free-running counter
    prev_acc     = -1;
    b2b          = 1'b1;
    bus.bin      = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2600; i++) begin
      @(posedge clk);
      #1;
      bus.bin = bus.bin + 8'd1;
    end
    bus.in_valid = 1'b0;
    b2b          = 1'b0;
    wait_done();
    check("b2b_drained", acc_v.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "bench timed out");
  end

endmodule
